// File: rtl/echo_detector.sv
// echo_detector: magnitude threshold echo detector with blanking, run confirmation, peak hold and timeout
module echo_detector #(
  parameter int n       = 16,
  parameter int CW      = 16,
  parameter int CONFIRM = 2
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          en,
  input  logic          start,
  input  logic          valid_i,
  input  logic [n-1:0]  data_i,
  input  logic [n-1:0]  threshold,
  input  logic [CW-1:0] blank_len,
  input  logic [CW-1:0] max_count,
  output logic [CW-1:0] tof_o,
  output logic [n-1:0]  peak_o,
  output logic          detect_o,
  output logic          timeout_o,
  output logic          busy_o
);
  typedef enum logic [1:0] {IDLE, BLANK, LISTEN, DONE} state_t;
  state_t        state;
  logic [n-1:0]  mag, abs_d;
  logic          mag_v, active, listen, hit, confirm, last;
  logic [CW-1:0] idx, cand, idx_nx;
  logic [3:0]    run, run_nx;
  always_comb begin
    abs_d   = data_i[n-1] ? -data_i : data_i;
    active  = mag_v && (state == BLANK || state == LISTEN);
    listen  = active && (state == LISTEN || idx >= blank_len);
    hit     = mag >= threshold;
    run_nx  = hit ? run + 4'd1 : 4'd0;
    confirm = hit && run_nx == 4'(CONFIRM);
    last    = max_count != '0 && idx == max_count - CW'(1);
    idx_nx  = &idx ? idx : idx + CW'(1);
  end
  // start has priority over the sample in flight, so that sample is discarded
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      mag       <= '0;
      mag_v     <= 1'b0;
      idx       <= '0;
      cand      <= '0;
      run       <= '0;
      tof_o     <= '0;
      peak_o    <= '0;
      detect_o  <= 1'b0;
      timeout_o <= 1'b0;
      busy_o    <= 1'b0;
    end else begin
      detect_o <= 1'b0;
      mag      <= abs_d;
      mag_v    <= en && !start && valid_i;
      if (!en) begin
        state  <= IDLE;
        busy_o <= 1'b0;
      end else if (start) begin
        state     <= BLANK;
        idx       <= '0;
        peak_o    <= '0;
        run       <= '0;
        timeout_o <= 1'b0;
        busy_o    <= 1'b1;
      end else if (active) begin
        idx <= idx_nx;
        if (listen) begin
          state <= LISTEN;
          run   <= run_nx;
          if (mag > peak_o) peak_o <= mag;
          if (hit && run == '0) cand <= idx;
          if (confirm) begin
            tof_o    <= run == '0 ? idx : cand;
            detect_o <= 1'b1;
            busy_o   <= 1'b0;
            state    <= DONE;
          end else if (last) begin
            tof_o     <= '1;
            timeout_o <= 1'b1;
            busy_o    <= 1'b0;
            state     <= DONE;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_echo_detector.sv
// tb_echo_detector: directed vectors with hand-computed expectations for echo_detector
module tb_echo_detector;
  logic        clk = 1'b0, rstn = 1'b0, en = 1'b1, start = 1'b0, valid_i = 1'b0;
  logic [15:0] data_i = '0, threshold = '0, blank_len = '0, max_count = '0;
  logic [15:0] tof_o, peak_o;
  logic        detect_o, timeout_o, busy_o;
  int          nvec = 0, nerr = 0;

  echo_detector dut (
    .clk(clk), .rstn(rstn), .en(en), .start(start), .valid_i(valid_i), .data_i(data_i),
    .threshold(threshold), .blank_len(blank_len), .max_count(max_count),
    .tof_o(tof_o), .peak_o(peak_o), .detect_o(detect_o), .timeout_o(timeout_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d);
    valid_i = 1'b1;
    data_i  = d;
    tick();
    valid_i = 1'b0;
  endtask

  task automatic go(input logic [15:0] thr, input logic [15:0] bl, input logic [15:0] mc);
    threshold = thr;
    blank_len = bl;
    max_count = mc;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    chk("rst_tof", tof_o, 0);
    chk("rst_peak", peak_o, 0);
    chk("rst_detect", detect_o, 0);
    chk("rst_timeout", timeout_o, 0);
    chk("rst_busy", busy_o, 0);
    rstn = 1'b1;
    tick();

    // basic echo: first ten samples blanked, run starts at idx 12
    go(16'd1000, 16'd10, 16'd0);
    chk("basic_busy", busy_o, 1);
    for (int i = 0; i < 10; i++) send(16'd2000);
    send(16'd0);
    send(16'd0);
    send(16'd1500);
    send(16'd1600);
    chk("basic_pre", detect_o, 0);
    tick();
    chk("basic_det", detect_o, 1);
    chk("basic_tof", tof_o, 12);
    chk("basic_peak", peak_o, 1600);
    chk("basic_busy_off", busy_o, 0);
    chk("basic_timeout", timeout_o, 0);
    tick();
    chk("basic_pulse", detect_o, 0);
    send(16'd5000);
    send(16'd5000);
    tick();
    chk("done_peak_hold", peak_o, 1600);
    chk("done_no_det", detect_o, 0);

    // broken run
    go(16'd1000, 16'd5, 16'd0);
    for (int i = 0; i < 5; i++) send(16'd3000);
    send(16'd1200);
    send(16'd500);
    send(16'd1100);
    send(-16'sd1300);
    tick();
    chk("brk_det", detect_o, 1);
    chk("brk_tof", tof_o, 7);
    chk("brk_peak", peak_o, 1300);

    // enable low mid-run
    go(16'd1000, 16'd0, 16'd0);
    send(16'd300);
    send(16'd300);
    en = 1'b0;
    tick();
    chk("en_busy", busy_o, 0);
    chk("en_tof_hold", tof_o, 7);
    chk("en_peak_hold", peak_o, 300);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("en_start_ign", busy_o, 0);
    en = 1'b1;
    send(16'd2000);
    send(16'd2000);
    tick();
    chk("idle_no_det", detect_o, 0);

    // negative full scale
    go(16'h8000, 16'd0, 16'd0);
    send(16'h8000);
    send(16'h8000);
    tick();
    chk("nfs_det", detect_o, 1);
    chk("nfs_peak", peak_o, 32768);
    chk("nfs_tof", tof_o, 0);

    // timeout after idx 19
    go(16'd1000, 16'd0, 16'd20);
    for (int i = 0; i < 20; i++) send(16'd0);
    chk("to_pre", timeout_o, 0);
    chk("to_pre_busy", busy_o, 1);
    tick();
    chk("to_flag", timeout_o, 1);
    chk("to_tof", tof_o, 16'hFFFF);
    chk("to_busy", busy_o, 0);
    chk("to_no_det", detect_o, 0);

    // detection on the final allowed sample beats timeout
    go(16'd1000, 16'd0, 16'd3);
    chk("tie_clear_to", timeout_o, 0);
    send(16'd0);
    send(16'd1500);
    send(16'd1500);
    tick();
    chk("tie_det", detect_o, 1);
    chk("tie_to", timeout_o, 0);
    chk("tie_tof", tof_o, 1);

    // reset mid-measurement
    go(16'd1000, 16'd0, 16'd0);
    send(16'd2000);
    send(16'd500);
    rstn = 1'b0;
    valid_i = 1'b1;
    data_i = 16'd2000;
    tick();
    valid_i = 1'b0;
    chk("mrst_tof", tof_o, 0);
    chk("mrst_peak", peak_o, 0);
    chk("mrst_busy", busy_o, 0);
    chk("mrst_det", detect_o, 0);
    rstn = 1'b1;
    tick();
    chk("mrst_no_det", detect_o, 0);

    // restart while listening: in-flight and coincident samples dropped
    go(16'd1000, 16'd0, 16'd0);
    for (int i = 0; i < 6; i++) send(16'd100);
    send(16'd900);
    start = 1'b1;
    valid_i = 1'b1;
    data_i = 16'd30000;
    tick();
    start = 1'b0;
    valid_i = 1'b0;
    chk("rs_peak_clr", peak_o, 0);
    tick();
    chk("rs_peak_drop", peak_o, 0);
    chk("rs_busy", busy_o, 1);
    send(16'd1500);
    send(16'd1500);
    tick();
    chk("rs_det", detect_o, 1);
    chk("rs_tof", tof_o, 0);
    chk("rs_peak", peak_o, 1500);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
